// File: rtl/mips_ctrl_pkg.sv
// Shared types and encodings for the multicycle MIPS control FSM.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    StRst, StFetch, StDecode, StMemAdr, StMemRd, StMemWb, StMemWr,
    StExec, StAluWb, StBranch, StJump, StImmEx, StImmWb, StErr
  } state_e;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpAndi  = 6'b001100;
  localparam logic [5:0] OpOri   = 6'b001101;

  localparam logic [1:0] AluAdd   = 2'b00;
  localparam logic [1:0] AluSub   = 2'b01;
  localparam logic [1:0] AluFunct = 2'b10;
  localparam logic [1:0] AluLogic = 2'b11;

  localparam logic [1:0] SrcBReg   = 2'b00;
  localparam logic [1:0] SrcBFour  = 2'b01;
  localparam logic [1:0] SrcBImm   = 2'b10;
  localparam logic [1:0] SrcBImmSh = 2'b11;

  localparam logic [1:0] PcAlu    = 2'b00;
  localparam logic [1:0] PcAluOut = 2'b01;
  localparam logic [1:0] PcJump   = 2'b10;

  function automatic logic is_zext_op(input logic [5:0] op);
    return (op == OpAndi) || (op == OpOri);
  endfunction

endpackage

// File: rtl/mips_ctrl_wait_timer.sv
// Memory wait counter: flags expiry on the TIMEOUT-th consecutive cycle without ready.
module mips_ctrl_wait_timer #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 8
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_start,
  input  logic i_ready,
  output logic o_expired
);

  localparam logic [CNT_W-1:0] LastWait = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] r_cnt;

  // i_start is held high outside waiting states, so the count is zero on entry.
  assign o_expired = !i_start && !i_ready && (r_cnt == LastWait);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_cnt <= '0;
    end else if (i_start || i_ready || o_expired) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM with memory-ready stalls and error traps.
// Define MIPS_ZERO_EXT_EN to accept andi/ori with zero-extended immediates.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 8
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [5:0] i_opcode,
  input  logic       i_zero,
  input  logic       i_mem_rdy,
  output logic       o_pc_we,
  output logic       o_pc_we_cond,
  output logic       o_iord,
  output logic       o_mem_rd,
  output logic       o_mem_wr,
  output logic       o_ir_we,
  output logic       o_reg_dst,
  output logic       o_mem_to_reg,
  output logic       o_reg_we,
  output logic       o_alu_src_a,
  output logic [1:0] o_alu_src_b,
  output logic [1:0] o_alu_op,
  output logic [1:0] o_pc_src,
  output logic       o_ext_sel,
  output logic       o_illegal_op,
  output logic       o_bus_err,
  output logic [3:0] o_state
);

  state_e r_state, w_next;
  logic   r_illegal, r_bus_err;
  logic   w_set_ill, w_set_bus;
  logic   w_wait_state, w_timer_clr, w_expired;
  logic   w_zext, w_imm_op;
  logic   w_unused_zero;

  // Branch condition is applied by the datapath through pc_we_cond.
  assign w_unused_zero = i_zero;

`ifdef MIPS_ZERO_EXT_EN
  assign w_zext = is_zext_op(i_opcode);
`else
  assign w_zext = 1'b0;
`endif

  assign w_imm_op     = (i_opcode == OpAddi) || w_zext;
  assign w_wait_state = (r_state == StFetch) || (r_state == StMemRd) || (r_state == StMemWr);
  assign w_timer_clr  = !w_wait_state;

  mips_ctrl_wait_timer #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_wait_timer (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_start   (w_timer_clr),
    .i_ready   (i_mem_rdy),
    .o_expired (w_expired)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state   <= StRst;
      r_illegal <= 1'b0;
      r_bus_err <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_set_ill) r_illegal <= 1'b1;
      if (w_set_bus) r_bus_err <= 1'b1;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_set_ill = 1'b0;
    w_set_bus = 1'b0;
    case (r_state)
      StRst:    w_next = StFetch;
      StFetch: begin
        if (i_mem_rdy) begin
          w_next = StDecode;
        end else if (w_expired) begin
          w_next    = StErr;
          w_set_bus = 1'b1;
        end
      end
      StDecode: begin
        if (i_opcode == OpRtype)                         w_next = StExec;
        else if ((i_opcode == OpLw) || (i_opcode == OpSw)) w_next = StMemAdr;
        else if (i_opcode == OpBeq)                      w_next = StBranch;
        else if (i_opcode == OpJ)                        w_next = StJump;
        else if (w_imm_op)                               w_next = StImmEx;
        else begin
          w_next    = StErr;
          w_set_ill = 1'b1;
        end
      end
      StMemAdr: w_next = (i_opcode == OpSw) ? StMemWr : StMemRd;
      StMemRd: begin
        if (i_mem_rdy) begin
          w_next = StMemWb;
        end else if (w_expired) begin
          w_next    = StErr;
          w_set_bus = 1'b1;
        end
      end
      StMemWr: begin
        if (i_mem_rdy) begin
          w_next = StFetch;
        end else if (w_expired) begin
          w_next    = StErr;
          w_set_bus = 1'b1;
        end
      end
      StMemWb:  w_next = StFetch;
      StExec:   w_next = StAluWb;
      StAluWb:  w_next = StFetch;
      StBranch: w_next = StFetch;
      StJump:   w_next = StFetch;
      StImmEx:  w_next = StImmWb;
      StImmWb:  w_next = StFetch;
      StErr:    w_next = StErr;
      default:  w_next = StRst;
    endcase
  end

  always_comb begin
    o_pc_we      = 1'b0;
    o_pc_we_cond = 1'b0;
    o_iord       = 1'b0;
    o_mem_rd     = 1'b0;
    o_mem_wr     = 1'b0;
    o_ir_we      = 1'b0;
    o_reg_dst    = 1'b0;
    o_mem_to_reg = 1'b0;
    o_reg_we     = 1'b0;
    o_alu_src_a  = 1'b0;
    o_alu_src_b  = SrcBReg;
    o_alu_op     = AluAdd;
    o_pc_src     = PcAlu;
    o_ext_sel    = 1'b0;
    case (r_state)
      StFetch: begin
        o_mem_rd    = 1'b1;
        o_alu_src_b = SrcBFour;
        o_ir_we     = i_mem_rdy;
        o_pc_we     = i_mem_rdy;
      end
      StDecode: o_alu_src_b = SrcBImmSh;
      StMemAdr: begin
        o_alu_src_a = 1'b1;
        o_alu_src_b = SrcBImm;
      end
      StMemRd: begin
        o_mem_rd = 1'b1;
        o_iord   = 1'b1;
      end
      StMemWb: begin
        o_reg_we     = 1'b1;
        o_mem_to_reg = 1'b1;
      end
      StMemWr: begin
        o_mem_wr = 1'b1;
        o_iord   = 1'b1;
      end
      StExec: begin
        o_alu_src_a = 1'b1;
        o_alu_op    = AluFunct;
      end
      StAluWb: begin
        o_reg_we  = 1'b1;
        o_reg_dst = 1'b1;
      end
      StBranch: begin
        o_alu_src_a  = 1'b1;
        o_alu_op     = AluSub;
        o_pc_src     = PcAluOut;
        o_pc_we_cond = 1'b1;
      end
      StJump: begin
        o_pc_src = PcJump;
        o_pc_we  = 1'b1;
      end
      StImmEx: begin
        o_alu_src_a = 1'b1;
        o_alu_src_b = SrcBImm;
        o_alu_op    = w_zext ? AluLogic : AluAdd;
        o_ext_sel   = w_zext;
      end
      StImmWb: begin
        o_reg_we  = 1'b1;
        o_alu_op  = w_zext ? AluLogic : AluAdd;
        o_ext_sel = w_zext;
      end
      default: ;
    endcase
  end

  assign o_illegal_op = r_illegal;
  assign o_bus_err    = r_bus_err;
  assign o_state      = r_state;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Table-driven, scoreboarded check of the multicycle MIPS control FSM (TIMEOUT=4).
module tb_mips_multicycle_ctrl;
  import mips_ctrl_pkg::*;

  typedef struct packed {
    logic       pc_we;
    logic       pc_we_cond;
    logic       iord;
    logic       mem_rd;
    logic       mem_wr;
    logic       ir_we;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_we;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       ext_sel;
    logic       illegal_op;
    logic       bus_err;
  } outs_t;

  typedef struct {
    logic       rst;
    logic [5:0] op;
    logic       zero;
    logic       rdy;
    state_e     st;
    outs_t      o;
  } vec_t;

  typedef struct {
    int     idx;
    state_e st;
    outs_t  o;
  } exp_t;

  localparam outs_t ONone    = '{default: '0};
  localparam outs_t OFetchW  = '{default: '0, mem_rd: 1'b1, alu_src_b: 2'b01};
  localparam outs_t OFetchR  = '{default: '0, mem_rd: 1'b1, alu_src_b: 2'b01, ir_we: 1'b1,
                                 pc_we: 1'b1};
  localparam outs_t ODecode  = '{default: '0, alu_src_b: 2'b11};
  localparam outs_t OMemAdr  = '{default: '0, alu_src_a: 1'b1, alu_src_b: 2'b10};
  localparam outs_t OMemRd   = '{default: '0, mem_rd: 1'b1, iord: 1'b1};
  localparam outs_t OMemWb   = '{default: '0, reg_we: 1'b1, mem_to_reg: 1'b1};
  localparam outs_t OMemWr   = '{default: '0, mem_wr: 1'b1, iord: 1'b1};
  localparam outs_t OExec    = '{default: '0, alu_src_a: 1'b1, alu_op: 2'b10};
  localparam outs_t OAluWb   = '{default: '0, reg_we: 1'b1, reg_dst: 1'b1};
  localparam outs_t OBranch  = '{default: '0, alu_src_a: 1'b1, alu_op: 2'b01, pc_src: 2'b01,
                                 pc_we_cond: 1'b1};
  localparam outs_t OJump    = '{default: '0, pc_src: 2'b10, pc_we: 1'b1};
  localparam outs_t OImmEx   = '{default: '0, alu_src_a: 1'b1, alu_src_b: 2'b10};
  localparam outs_t OImmWb   = '{default: '0, reg_we: 1'b1};
  localparam outs_t OImmExZ  = '{default: '0, alu_src_a: 1'b1, alu_src_b: 2'b10, alu_op: 2'b11,
                                 ext_sel: 1'b1};
  localparam outs_t OImmWbZ  = '{default: '0, reg_we: 1'b1, alu_op: 2'b11, ext_sel: 1'b1};
  localparam outs_t OErrIll  = '{default: '0, illegal_op: 1'b1};
  localparam outs_t OErrBus  = '{default: '0, bus_err: 1'b1};

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] opcode = '0;
  logic       zero = 1'b0;
  logic       mem_rdy = 1'b0;
  logic       pc_we, pc_we_cond, iord, mem_rd, mem_wr, ir_we, reg_dst, mem_to_reg, reg_we;
  logic       alu_src_a, ext_sel, illegal_op, bus_err;
  logic [1:0] alu_src_b, alu_op, pc_src;
  logic [3:0] state;

  mips_multicycle_ctrl #(
    .TIMEOUT (4),
    .CNT_W   (3)
  ) dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_opcode     (opcode),
    .i_zero       (zero),
    .i_mem_rdy    (mem_rdy),
    .o_pc_we      (pc_we),
    .o_pc_we_cond (pc_we_cond),
    .o_iord       (iord),
    .o_mem_rd     (mem_rd),
    .o_mem_wr     (mem_wr),
    .o_ir_we      (ir_we),
    .o_reg_dst    (reg_dst),
    .o_mem_to_reg (mem_to_reg),
    .o_reg_we     (reg_we),
    .o_alu_src_a  (alu_src_a),
    .o_alu_src_b  (alu_src_b),
    .o_alu_op     (alu_op),
    .o_pc_src     (pc_src),
    .o_ext_sel    (ext_sel),
    .o_illegal_op (illegal_op),
    .o_bus_err    (bus_err),
    .o_state      (state)
  );

  always #5 clk = ~clk;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  function automatic outs_t act_outs();
    return '{pc_we: pc_we, pc_we_cond: pc_we_cond, iord: iord, mem_rd: mem_rd, mem_wr: mem_wr,
             ir_we: ir_we, reg_dst: reg_dst, mem_to_reg: mem_to_reg, reg_we: reg_we,
             alu_src_a: alu_src_a, alu_src_b: alu_src_b, alu_op: alu_op, pc_src: pc_src,
             ext_sel: ext_sel, illegal_op: illegal_op, bus_err: bus_err};
  endfunction

  function automatic void add(input logic r, input logic [5:0] op, input logic z, input logic rd,
                              input state_e st, input outs_t o);
    vec_t v;
    v.rst = r; v.op = op; v.zero = z; v.rdy = rd; v.st = st; v.o = o;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input exp_t e);
    outs_t a;
    a = act_outs();
    n_vec++;
    if (state !== 4'(e.st) || a !== e.o) begin
      n_miss++;
      $display("FAIL %s #%0d: got state=%0d outs=%05h, required state=%0d outs=%05h",
               name, e.idx, state, a, 4'(e.st), e.o);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    exp_t e;
    @(posedge clk);
    #1;
    reset   = v.rst;
    opcode  = v.op;
    zero    = v.zero;
    mem_rdy = v.rdy;
    sb.push_back('{idx: idx, st: v.st, o: v.o});
    @(negedge clk);
    if (sb.size() == 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL scoreboard #%0d: got empty queue, required one entry", idx);
    end else begin
      e = sb.pop_front();
      check("vec", e);
    end
  endtask

  initial begin
    logic [5:0] bad_op;
    exp_t       e;
    bad_op = 6'b111111;

    add(1, OpRtype, 0, 1, StRst, ONone);
    add(0, OpRtype, 0, 1, StRst, ONone);
    // add: 4 cycles
    add(0, OpRtype, 0, 1, StFetch, OFetchR);
    add(0, OpRtype, 0, 1, StDecode, ODecode);
    add(0, OpRtype, 0, 1, StExec, OExec);
    add(0, OpRtype, 0, 1, StAluWb, OAluWb);
    // lw with three wait cycles; ready lands on the TIMEOUT-th wait
    add(0, OpLw, 0, 1, StFetch, OFetchR);
    add(0, OpLw, 0, 1, StDecode, ODecode);
    add(0, OpLw, 0, 1, StMemAdr, OMemAdr);
    add(0, OpLw, 0, 0, StMemRd, OMemRd);
    add(0, OpLw, 0, 0, StMemRd, OMemRd);
    add(0, OpLw, 0, 0, StMemRd, OMemRd);
    add(0, OpLw, 0, 1, StMemRd, OMemRd);
    add(0, OpLw, 0, 1, StMemWb, OMemWb);
    add(0, OpSw, 0, 1, StFetch, OFetchR);
    add(0, OpSw, 0, 1, StDecode, ODecode);
    add(0, OpSw, 0, 1, StMemAdr, OMemAdr);
    add(0, OpSw, 0, 1, StMemWr, OMemWr);
    add(0, OpBeq, 1, 1, StFetch, OFetchR);
    add(0, OpBeq, 1, 1, StDecode, ODecode);
    add(0, OpBeq, 1, 1, StBranch, OBranch);
    add(0, OpJ, 0, 1, StFetch, OFetchR);
    add(0, OpJ, 0, 1, StDecode, ODecode);
    add(0, OpJ, 0, 1, StJump, OJump);
    add(0, OpAddi, 0, 1, StFetch, OFetchR);
    add(0, OpAddi, 0, 1, StDecode, ODecode);
    add(0, OpAddi, 0, 1, StImmEx, OImmEx);
    add(0, OpAddi, 0, 1, StImmWb, OImmWb);
    // fetch stall that completes exactly at the timeout boundary
    add(0, OpJ, 0, 0, StFetch, OFetchW);
    add(0, OpJ, 0, 0, StFetch, OFetchW);
    add(0, OpJ, 0, 0, StFetch, OFetchW);
    add(0, OpJ, 0, 1, StFetch, OFetchR);
    add(0, OpJ, 0, 1, StDecode, ODecode);
    add(0, OpJ, 0, 1, StJump, OJump);
    add(0, OpOri, 0, 1, StFetch, OFetchR);
    add(0, OpOri, 0, 1, StDecode, ODecode);
`ifdef MIPS_ZERO_EXT_EN
    add(0, OpOri, 0, 1, StImmEx, OImmExZ);
    add(0, OpOri, 0, 1, StImmWb, OImmWbZ);
`else
    add(0, OpOri, 0, 1, StErr, OErrIll);
    add(0, OpOri, 0, 1, StErr, OErrIll);
    add(1, OpOri, 0, 1, StRst, ONone);
    add(0, OpOri, 0, 1, StRst, ONone);
`endif
    add(0, bad_op, 0, 1, StFetch, OFetchR);
    add(0, bad_op, 0, 1, StDecode, ODecode);
    add(0, bad_op, 0, 1, StErr, OErrIll);
    add(0, bad_op, 0, 0, StErr, OErrIll);
    add(1, bad_op, 0, 0, StRst, ONone);
    add(0, bad_op, 0, 0, StRst, ONone);
    // fetch stall that runs out: four waits then bus error
    add(0, OpRtype, 0, 0, StFetch, OFetchW);
    add(0, OpRtype, 0, 0, StFetch, OFetchW);
    add(0, OpRtype, 0, 0, StFetch, OFetchW);
    add(0, OpRtype, 0, 0, StFetch, OFetchW);
    add(0, OpRtype, 0, 0, StErr, OErrBus);
    add(0, OpRtype, 0, 1, StErr, OErrBus);
    // walk a store into MEMWR and leave it stalled
    add(1, OpSw, 0, 1, StRst, ONone);
    add(0, OpSw, 0, 1, StRst, ONone);
    add(0, OpSw, 0, 1, StFetch, OFetchR);
    add(0, OpSw, 0, 1, StDecode, ODecode);
    add(0, OpSw, 0, 1, StMemAdr, OMemAdr);
    add(0, OpSw, 0, 0, StMemWr, OMemWr);

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

    // Reset mid-MEMWR: write strobe must drop without waiting for a clock edge.
    #2;
    reset = 1'b1;
    #1;
    e = '{idx: 0, st: StRst, o: ONone};
    check("async_reset", e);
    for (int i = 1; i <= 2; i++) begin
      @(negedge clk);
      e = '{idx: i, st: StRst, o: ONone};
      check("reset_hold", e);
    end
    @(posedge clk);
    #1;
    reset   = 1'b0;
    mem_rdy = 1'b1;
    opcode  = OpRtype;
    @(negedge clk);
    e = '{idx: 0, st: StRst, o: ONone};
    check("reset_release", e);
    @(negedge clk);
    e = '{idx: 1, st: StFetch, o: OFetchR};
    check("reset_release", e);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
